// File: rtl/parser_pkg.sv
// Shared parser types: rule records and lookup results, sized from the default layer geometry.
package parser_pkg;

  localparam int PKG_HEAD_WIDTH = 512;
  localparam int PKG_TYPE_WIDTH = 8;
  localparam int PKG_TYPE_NUM   = 2;
  localparam int PKG_RULE_NUM   = 8;
  localparam int PKG_KEY_NUM    = 4;
  localparam int PKG_CNT_WIDTH  = 32;

  localparam int HEAD_BYTES = PKG_HEAD_WIDTH / 8;
  // One extra bit lets an offset point past the header, which extracts as zero.
  localparam int TYPE_OFFSET_WIDTH = $clog2(HEAD_BYTES) + 1;
  localparam int KEY_OFFSET_WIDTH  = $clog2(HEAD_BYTES);
  localparam int REP_OFFSET_WIDTH  = $clog2(HEAD_BYTES);
  localparam int SHIFT_WIDTH       = $clog2(HEAD_BYTES) + 1;

  typedef struct packed {
    logic [PKG_TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0] typeOffset;
    logic [PKG_KEY_NUM-1:0]                         keyOffset_v;
    logic [PKG_KEY_NUM-1:0][KEY_OFFSET_WIDTH-1:0]   keyOffset;
    logic [SHIFT_WIDTH-1:0]                         headShift;
    logic [SHIFT_WIDTH-1:0]                         metaShift;
    logic [REP_OFFSET_WIDTH:0]                      replaceOffset;  // MSB = replace enable
  } lookup_rst_t;

  typedef struct packed {
    logic                                        typeRule_valid;
    logic [PKG_TYPE_NUM-1:0][PKG_TYPE_WIDTH-1:0] typeData;
    logic [PKG_TYPE_NUM-1:0][PKG_TYPE_WIDTH-1:0] typeMask;
    lookup_rst_t                                 result;
  } type_rule_v2_t;

endpackage

// File: rtl/parser_type_match.sv
// Single-rule masked compare of TYPE_NUM extracted type fields.
module parser_type_match
  import parser_pkg::*;
#(
  parameter int TYPE_WIDTH = PKG_TYPE_WIDTH,
  parameter int TYPE_NUM   = PKG_TYPE_NUM
) (
  input  logic                           i_valid,
  input  logic [TYPE_NUM*TYPE_WIDTH-1:0] i_field,
  input  logic [TYPE_NUM*TYPE_WIDTH-1:0] i_data,
  input  logic [TYPE_NUM*TYPE_WIDTH-1:0] i_mask,
  output logic                           o_match
);

  always_comb begin
    o_match = i_valid;
    for (int t = 0; t < TYPE_NUM; t++) begin
      if (((i_field[t*TYPE_WIDTH +: TYPE_WIDTH] ^ i_data[t*TYPE_WIDTH +: TYPE_WIDTH])
           & i_mask[t*TYPE_WIDTH +: TYPE_WIDTH]) != '0) begin
        o_match = 1'b0;
      end
    end
  end

endmodule

// File: rtl/parser_layer_lookup.sv
// Per-layer type lookup: extract type bytes, match a writable masked rule table, return the
// lowest-index winning rule through a two-stage valid/ready pipeline.
module parser_layer_lookup
  import parser_pkg::*;
#(
  parameter int HEAD_WIDTH = PKG_HEAD_WIDTH,
  parameter int TYPE_WIDTH = PKG_TYPE_WIDTH,
  parameter int TYPE_NUM   = PKG_TYPE_NUM,
  parameter int RULE_NUM   = PKG_RULE_NUM,
  parameter int CNT_WIDTH  = PKG_CNT_WIDTH
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic                                  i_head_valid,
  output logic                                  o_head_ready,
  input  logic [HEAD_WIDTH-1:0]                 i_head,
  input  logic [TYPE_NUM*TYPE_OFFSET_WIDTH-1:0] i_type_offset,
  input  logic                                  i_rule_wr,
  input  logic [$clog2(RULE_NUM)-1:0]           i_rule_idx,
  input  logic [$bits(type_rule_v2_t)-1:0]      i_rule,
  input  logic                                  i_rule_clr,
  output logic                                  o_rst_valid,
  input  logic                                  i_rst_ready,
  output logic [$bits(lookup_rst_t)-1:0]        o_rst,
  output logic                                  o_rst_hit,
  output logic [$clog2(RULE_NUM)-1:0]           o_rst_idx,
  output logic [HEAD_WIDTH-1:0]                 o_head,
  output logic [CNT_WIDTH-1:0]                  o_hit_cnt,
  output logic [CNT_WIDTH-1:0]                  o_miss_cnt
);

  localparam int IDX_W  = $clog2(RULE_NUM);
  localparam int NBYTES = HEAD_WIDTH / 8;
  localparam int TOW    = TYPE_OFFSET_WIDTH;

  typedef logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0] fields_t;

  type_rule_v2_t       w_rule;
  fields_t             w_field;
  logic                w_s2_en;
  logic                w_accept;
  logic                w_s2_load;
  logic [RULE_NUM-1:0] w_match;
  logic                w_hit;
  logic [IDX_W-1:0]    w_idx;
  lookup_rst_t         w_result;

  logic [RULE_NUM-1:0] r_valid;
  fields_t             r_data   [RULE_NUM];
  fields_t             r_mask   [RULE_NUM];
  lookup_rst_t         r_result [RULE_NUM];

  logic                r_s1_valid;
  logic [HEAD_WIDTH-1:0] r_s1_head;
  fields_t             r_s1_field;

  logic                r_s2_valid;
  logic [HEAD_WIDTH-1:0] r_s2_head;
  lookup_rst_t         r_s2_rst;
  logic                r_s2_hit;
  logic [IDX_W-1:0]    r_s2_idx;
  logic [CNT_WIDTH-1:0] r_hit_cnt;
  logic [CNT_WIDTH-1:0] r_miss_cnt;

  assign w_rule       = type_rule_v2_t'(i_rule);
  assign w_s2_en      = !r_s2_valid || i_rst_ready;
  assign o_head_ready = i_rst_n && (!r_s1_valid || w_s2_en);
  assign w_accept     = i_head_valid && o_head_ready;
  assign w_s2_load    = w_s2_en && r_s1_valid;

  // Byte-select mux per type field; offsets beyond the header match no byte and stay zero.
  always_comb begin
    w_field = '0;
    for (int t = 0; t < TYPE_NUM; t++) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (i_type_offset[t*TOW +: TOW] == TOW'(b)) begin
          w_field[t] = TYPE_WIDTH'(i_head[HEAD_WIDTH-1-8*b -: 8]);
        end
      end
    end
  end

  // Rule table: clear first, then the write, so a same-cycle write survives the clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
    end else begin
      if (i_rule_clr) r_valid <= '0;
      if (i_rule_wr)  r_valid[i_rule_idx] <= w_rule.typeRule_valid;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rule_wr) begin
      r_data[i_rule_idx]   <= w_rule.typeData;
      r_mask[i_rule_idx]   <= w_rule.typeMask;
      r_result[i_rule_idx] <= w_rule.result;
    end
  end

  // ---- Stage 1: capture header and extracted type fields ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
    end else if (o_head_ready) begin
      r_s1_valid <= i_head_valid;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_s1_head  <= i_head;
      r_s1_field <= w_field;
    end
  end

  for (genvar r = 0; r < RULE_NUM; r++) begin : g_match
    parser_type_match #(
      .TYPE_WIDTH (TYPE_WIDTH),
      .TYPE_NUM   (TYPE_NUM)
    ) u_match (
      .i_valid (r_valid[r]),
      .i_field (r_s1_field),
      .i_data  (r_data[r]),
      .i_mask  (r_mask[r]),
      .o_match (w_match[r])
    );
  end

  always_comb begin
    w_hit    = 1'b0;
    w_idx    = '0;
    w_result = '0;
    for (int r = RULE_NUM - 1; r >= 0; r--) begin
      if (w_match[r]) begin
        w_hit = 1'b1;
        w_idx = IDX_W'(r);
      end
    end
    if (w_hit) w_result = r_result[w_idx];
  end

  // ---- Stage 2: registered result, aligned header and counters ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_head  <= '0;
      r_s2_rst   <= '0;
      r_s2_hit   <= 1'b0;
      r_s2_idx   <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_s2_en) r_s2_valid <= r_s1_valid;
      if (w_s2_load) begin
        r_s2_head <= r_s1_head;
        r_s2_rst  <= w_result;
        r_s2_hit  <= w_hit;
        r_s2_idx  <= w_idx;
        if (w_hit) r_hit_cnt  <= r_hit_cnt + CNT_WIDTH'(1);
        else       r_miss_cnt <= r_miss_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign o_rst_valid = r_s2_valid;
  assign o_rst       = r_s2_rst;
  assign o_rst_hit   = r_s2_hit;
  assign o_rst_idx   = r_s2_idx;
  assign o_head      = r_s2_head;
  assign o_hit_cnt   = r_hit_cnt;
  assign o_miss_cnt  = r_miss_cnt;

endmodule

// File: tb/tb_parser_layer_lookup.sv
// Bench for parser_layer_lookup: directed lookups against a table-level reference model.
module tb_parser_layer_lookup;
  import parser_pkg::*;

  localparam int HW  = PKG_HEAD_WIDTH;
  localparam int TN  = PKG_TYPE_NUM;
  localparam int RN  = PKG_RULE_NUM;
  localparam int TOW = TYPE_OFFSET_WIDTH;
  localparam int IW  = $clog2(RN);
  localparam int CW  = PKG_CNT_WIDTH;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      head_valid;
  logic                      head_ready;
  logic [HW-1:0]             head;
  logic [TN*TOW-1:0]         toff;
  logic                      rule_wr;
  logic [IW-1:0]             rule_idx;
  type_rule_v2_t             rule;
  logic                      rule_clr;
  logic                      rst_valid;
  logic                      rst_ready;
  logic [$bits(lookup_rst_t)-1:0] rst_o;
  logic                      rst_hit;
  logic [IW-1:0]             rst_idx;
  logic [HW-1:0]             head_o;
  logic [CW-1:0]             hit_cnt;
  logic [CW-1:0]             miss_cnt;

  always #5 clk = ~clk;

  parser_layer_lookup dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_head_valid  (head_valid),
    .o_head_ready  (head_ready),
    .i_head        (head),
    .i_type_offset (toff),
    .i_rule_wr     (rule_wr),
    .i_rule_idx    (rule_idx),
    .i_rule        (rule),
    .i_rule_clr    (rule_clr),
    .o_rst_valid   (rst_valid),
    .i_rst_ready   (rst_ready),
    .o_rst         (rst_o),
    .o_rst_hit     (rst_hit),
    .o_rst_idx     (rst_idx),
    .o_head        (head_o),
    .o_hit_cnt     (hit_cnt),
    .o_miss_cnt    (miss_cnt)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic chk(input string nm, input logic [HW-1:0] act, input logic [HW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: table contents plus one slot per pipeline stage.
  logic          m_tv [RN];
  type_rule_v2_t m_tr [RN];
  logic          m_s1v, m_s2v;
  logic [HW-1:0] m_s1_head, m_s2_head;
  logic [TN*TOW-1:0] m_s1_off;
  logic          m_s2_hit;
  logic [IW-1:0] m_s2_idx;
  lookup_rst_t   m_s2_rst;
  logic [CW-1:0] m_hit_cnt, m_miss_cnt;

  function automatic logic [7:0] hbyte(input logic [HW-1:0] h, input int off);
    if (off >= HW / 8) return 8'h00;
    return h[HW-1-8*off -: 8];
  endfunction

  task automatic model_lookup(input logic [HW-1:0] h, input logic [TN*TOW-1:0] off,
                              output logic hit, output logic [IW-1:0] idx, output lookup_rst_t res);
    logic ok;
    logic [7:0] f;
    hit = 1'b0; idx = '0; res = '0;
    for (int r = 0; r < RN; r++) begin
      if (!hit && m_tv[r]) begin
        ok = 1'b1;
        for (int t = 0; t < TN; t++) begin
          f = hbyte(h, int'(off[t*TOW +: TOW]));
          if (((f ^ m_tr[r].typeData[t]) & m_tr[r].typeMask[t]) != 8'h00) ok = 1'b0;
        end
        if (ok) begin hit = 1'b1; idx = IW'(r); res = m_tr[r].result; end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int r = 0; r < RN; r++) m_tv[r] = 1'b0;
      m_s1v = 0; m_s2v = 0; m_s2_head = '0; m_s2_hit = 0; m_s2_idx = '0; m_s2_rst = '0;
      m_hit_cnt = '0; m_miss_cnt = '0;
    end else begin
      logic s2en, acc;
      s2en = !m_s2v || rst_ready;
      acc  = head_valid && (!m_s1v || s2en);
      if (s2en) begin
        if (m_s1v) begin
          model_lookup(m_s1_head, m_s1_off, m_s2_hit, m_s2_idx, m_s2_rst);
          m_s2_head = m_s1_head;
          if (m_s2_hit) m_hit_cnt++; else m_miss_cnt++;
        end
        m_s2v = m_s1v;
      end
      if (!m_s1v || s2en) begin
        m_s1v = acc;
        if (acc) begin m_s1_head = head; m_s1_off = toff; end
      end
      if (rule_clr) for (int r = 0; r < RN; r++) m_tv[r] = 1'b0;
      if (rule_wr) begin m_tv[rule_idx] = rule.typeRule_valid; m_tr[rule_idx] = rule; end
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Per-cycle compare, stall-stability check, and an in-order log of consumed results.
  logic [HW-1:0] rx_q [$];
  logic          prev_stall = 1'b0;
  logic [HW-1:0] prev_head, prev_res;

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("head_ready", head_ready, !m_s1v || !m_s2v || rst_ready);
      chk("rst_valid", rst_valid, m_s2v);
      chk("hit_cnt", hit_cnt, m_hit_cnt);
      chk("miss_cnt", miss_cnt, m_miss_cnt);
      if (m_s2v && rst_valid) begin
        chk("rst", rst_o, m_s2_rst);
        chk("rst_hit", rst_hit, m_s2_hit);
        chk("rst_idx", rst_idx, m_s2_idx);
        chk("head_o", head_o, m_s2_head);
      end
      if (prev_stall) begin
        chk("stable_res", {rst_o, rst_idx, rst_hit}, prev_res);
        chk("stable_head", head_o, prev_head);
      end
      prev_stall = rst_valid && !rst_ready;
      prev_res   = HW'({rst_o, rst_idx, rst_hit});
      prev_head  = head_o;
      if (rst_valid && rst_ready) rx_q.push_back(HW'({rst_idx, head_o[31:0]}));
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [HW-1:0] mkh(input int tag, input int o0, input logic [7:0] b0,
                                        input int o1, input logic [7:0] b1);
    logic [HW-1:0] h;
    h = '0;
    h[31:0] = tag;
    h[HW-1-8*o0 -: 8] = b0;
    h[HW-1-8*o1 -: 8] = b1;
    return h;
  endfunction

  function automatic logic [TN*TOW-1:0] mko(input int a, input int b);
    return {TOW'(b), TOW'(a)};
  endfunction

  function automatic type_rule_v2_t mkr(input logic v, input logic [7:0] d0, input logic [7:0] d1,
                                        input logic [7:0] m0, input logic [7:0] m1, input int hs);
    type_rule_v2_t r;
    r = '0;
    r.typeRule_valid = v;
    r.typeData[0] = d0; r.typeData[1] = d1;
    r.typeMask[0] = m0; r.typeMask[1] = m1;
    r.result.typeOffset[0] = TOW'(hs + 1);
    r.result.typeOffset[1] = TOW'(hs + 3);
    r.result.keyOffset_v   = 4'(hs);
    r.result.keyOffset[0]  = KEY_OFFSET_WIDTH'(hs + 10);
    r.result.headShift     = SHIFT_WIDTH'(hs);
    r.result.metaShift     = SHIFT_WIDTH'(hs + 2);
    r.result.replaceOffset = {1'b1, REP_OFFSET_WIDTH'(hs)};
    return r;
  endfunction

  task automatic wr_rule(input int idx, input type_rule_v2_t r, input logic clr);
    rule_wr = 1'b1; rule_idx = IW'(idx); rule = r; rule_clr = clr;
    tick();
    rule_wr = 1'b0; rule_clr = 1'b0;
  endtask

  task automatic send(input logic [HW-1:0] h, input logic [TN*TOW-1:0] o);
    logic acc;
    int n;
    head_valid = 1'b1; head = h; toff = o;
    n = 0;
    do begin
      acc = head_ready;
      tick();
      n++;
    end while (!acc && n < 40);
    if (!acc) chk("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic lookup1(input logic [HW-1:0] h, input logic [TN*TOW-1:0] o,
                         output int lat, output logic hit, output logic [IW-1:0] idx,
                         output lookup_rst_t res, output logic [CW-1:0] hc, output logic [CW-1:0] mc);
    send(h, o);
    head_valid = 1'b0;
    lat = 0; hit = 0; idx = '0; res = '0; hc = '0; mc = '0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (rst_valid) begin
        lat = n; hit = rst_hit; idx = rst_idx; res = lookup_rst_t'(rst_o);
        hc = hit_cnt; mc = miss_cnt;
        break;
      end
    end
    if (lat == 0) chk("result_timeout", 1'b0, 1'b1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic hit;
    logic [IW-1:0] idx;
    lookup_rst_t res;
    logic [CW-1:0] hc, mc;
    logic [HW-1:0] h_basic, h5;
    int c0;

    rst_n = 1'b0; head_valid = 0; head = '0; toff = '0;
    rule_wr = 0; rule_idx = '0; rule = '0; rule_clr = 0; rst_ready = 1'b1;
    repeat (3) tick();
    chk("reset_head_ready", head_ready, 1'b0);
    chk("reset_rst_valid", rst_valid, 1'b0);
    chk("reset_rst", rst_o, '0);
    chk("reset_head_o", head_o, '0);
    chk("reset_cnts", {hit_cnt, miss_cnt}, '0);
    rst_n = 1'b1;
    #1;
    chk("release_head_ready", head_ready, 1'b1);
    tick();

    // Empty table: every lookup misses, including an out-of-range offset.
    for (int k = 0; k < 4; k++)
      send(mkh(10 + k, 12, 8'h08, 13, 8'h00), (k == 3) ? mko(70, 13) : mko(12 + k, 13));
    head_valid = 1'b0;
    repeat (4) tick();
    chk("miss4_miss_cnt", miss_cnt, 32'd4);
    chk("miss4_hit_cnt", hit_cnt, 32'd0);

    // Basic hit on rule 3.
    h_basic = mkh(1, 12, 8'h08, 13, 8'h00);
    wr_rule(3, mkr(1, 8'h08, 8'h00, 8'hFF, 8'hFF, 7), 1'b0);
    lookup1(h_basic, mko(12, 13), lat, hit, idx, res, hc, mc);
    chk("basic_latency", lat, 2);
    chk("basic_hit", hit, 1'b1);
    chk("basic_idx", idx, 3'd3);
    chk("basic_headShift", res.headShift, 7'd7);
    chk("basic_replace", res.replaceOffset, 7'h47);
    chk("basic_hit_cnt", hc, 32'd1);

    // Wildcard rule 1 outranks rule 3 until it is invalidated.
    wr_rule(1, mkr(1, 8'h00, 8'h00, 8'h00, 8'h00, 1), 1'b0);
    lookup1(h_basic, mko(12, 13), lat, hit, idx, res, hc, mc);
    chk("prio_wild_idx", idx, 3'd1);
    lookup1(mkh(2, 5, 8'h77, 6, 8'h99), mko(5, 6), lat, hit, idx, res, hc, mc);
    chk("prio_any_idx", idx, 3'd1);
    wr_rule(1, mkr(0, 8'h00, 8'h00, 8'h00, 8'h00, 1), 1'b0);
    lookup1(h_basic, mko(12, 13), lat, hit, idx, res, hc, mc);
    chk("prio_after_inval_idx", idx, 3'd3);

    // Offset 70 extracts 0x00.
    wr_rule(2, mkr(1, 8'h00, 8'h5A, 8'hFF, 8'hFF, 9), 1'b0);
    lookup1(mkh(3, 20, 8'h5A, 12, 8'h08), mko(70, 20), lat, hit, idx, res, hc, mc);
    chk("off70_hit", hit, 1'b1);
    chk("off70_idx", idx, 3'd2);
    lookup1(mkh(4, 20, 8'h5A, 21, 8'h11), mko(21, 20), lat, hit, idx, res, hc, mc);
    chk("miss_hit", hit, 1'b0);
    chk("miss_idx", idx, 3'd0);
    chk("miss_rst", res, '0);

    // Back-to-back headers with downstream ready toggling.
    rx_q.delete();
    fork
      begin
        for (int k = 0; k < 10; k++)
          send(mkh(100 + k, 12, k[0] ? 8'h33 : 8'h08, 13, 8'h00), mko(12, 13));
        head_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 40; i++) begin
          rst_ready = !i[0];
          tick();
        end
      end
    join
    rst_ready = 1'b1;
    repeat (4) tick();
    chk("bp_count", rx_q.size(), 10);
    for (int k = 0; k < 10 && k < rx_q.size(); k++)
      chk("bp_order", rx_q[k], HW'({k[0] ? 3'd0 : 3'd3, 32'(100 + k)}));

    // Full throughput: 10 headers in 12 cycles.
    rx_q.delete();
    c0 = cyc;
    for (int k = 0; k < 10; k++) send(mkh(150 + k, 12, 8'h08, 13, 8'h00), mko(12, 13));
    head_valid = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      #1;
      if (rx_q.size() == 10) break;
    end
    chk("thru_cycles", cyc - c0 + 1, 12);
    tick();
    repeat (2) tick();

    // Write racing a header's S1->S2 move.
    rx_q.delete();
    head_valid = 1'b1; head = mkh(200, 12, 8'h08, 13, 8'h00); toff = mko(12, 13);
    tick();
    head = mkh(201, 12, 8'h08, 13, 8'h00);
    rule_wr = 1'b1; rule_idx = 3'd0; rule = mkr(1, 8'h00, 8'h00, 8'h00, 8'h00, 4);
    tick();
    head_valid = 1'b0; rule_wr = 1'b0;
    repeat (4) tick();
    chk("race_count", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      chk("race_old_table", rx_q[0], HW'({3'd3, 32'd200}));
      chk("race_new_table", rx_q[1], HW'({3'd0, 32'd201}));
    end

    // Clear plus write of rule 5 in one cycle.
    h5 = mkh(5, 30, 8'hAA, 31, 8'hBB);
    wr_rule(5, mkr(1, 8'hAA, 8'hBB, 8'hFF, 8'hFF, 11), 1'b1);
    lookup1(h_basic, mko(12, 13), lat, hit, idx, res, hc, mc);
    chk("clr_old_gone", hit, 1'b0);
    lookup1(h5, mko(30, 31), lat, hit, idx, res, hc, mc);
    chk("clr_rule5_hit", hit, 1'b1);
    chk("clr_rule5_idx", idx, 3'd5);

    // Reset with both stages full.
    rst_ready = 1'b0;
    head_valid = 1'b1; head = h5; toff = mko(30, 31);
    tick();
    head = mkh(6, 30, 8'hAA, 31, 8'hBB);
    tick();
    head_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rst_valid", rst_valid, 1'b0);
    chk("midrst_head_ready", head_ready, 1'b0);
    chk("midrst_outs", {rst_o, rst_hit, rst_idx}, '0);
    chk("midrst_head_o", head_o, '0);
    chk("midrst_cnts", {hit_cnt, miss_cnt}, '0);
    tick();
    rst_n = 1'b1; rst_ready = 1'b1;
    tick();
    lookup1(h5, mko(30, 31), lat, hit, idx, res, hc, mc);
    chk("postrst_hit", hit, 1'b0);
    chk("postrst_miss_cnt", mc, 32'd1);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
